// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: read-side bundle of the async FIFO (sync'd write pointer,
// memory read port, FWFT consumer port and status).
interface fifo_rd_ctrl_if #(parameter int ASIZE = 4, parameter int DSIZE = 8);
  logic [ASIZE:0]   rq2_wptr;
  logic [DSIZE-1:0] mem_rdata;
  logic             rready;
  logic [ASIZE:0]   rptr;
  logic [ASIZE-1:0] raddr;
  logic [DSIZE-1:0] rdata;
  logic             rvalid;
  logic             rempty;
  logic             raempty;
  logic [ASIZE:0]   rlevel;
  modport slave (
    input  rq2_wptr, mem_rdata, rready,
    output rptr, raddr, rdata, rvalid, rempty, raempty, rlevel
  );
  modport master (
    output rq2_wptr, mem_rdata, rready,
    input  rptr, raddr, rdata, rvalid, rempty, raempty, rlevel
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async FIFO read controller with a first-word-fall-through output register.
module fifo_rd_ctrl #(
  parameter int ASIZE  = 4,
  parameter int DSIZE  = 8,
  parameter int AEMPTY = 2
) (
  input logic rclk,
  input logic rrst_n,
  fifo_rd_ctrl_if.slave rif
);
  logic [ASIZE:0]   rbin, rptr, rlevel, wbin, rbinnext, rgraynext, rlevel_next;
  logic [DSIZE-1:0] rdata;
  logic             rvalid, rempty, raempty, fetch, rvalid_next;
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ASIZE; i++) wbin[i] = ^(rif.rq2_wptr >> i);
    fetch       = !rempty && (!rvalid || rif.rready);
    rvalid_next = fetch || (rvalid && !rif.rready);
    rbinnext    = rbin + (ASIZE+1)'(fetch);
    rgraynext   = rbinnext ^ (rbinnext >> 1);
    // memory words still unread plus the one parked in the output register
    rlevel_next = wbin - rbinnext + (ASIZE+1)'(rvalid_next);
  end
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin    <= '0;
      rptr    <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
      rempty  <= 1'b1;
      rlevel  <= '0;
      raempty <= 1'b1;
    end else begin
      if (fetch) rdata <= rif.mem_rdata;
      rbin    <= rbinnext;
      rptr    <= rgraynext;
      rvalid  <= rvalid_next;
      rempty  <= rgraynext == rif.rq2_wptr;
      rlevel  <= rlevel_next;
      raempty <= rlevel_next <= (ASIZE+1)'(AEMPTY);
    end
  end
  assign rif.raddr   = rbin[ASIZE-1:0];
  assign rif.rptr    = rptr;
  assign rif.rdata   = rdata;
  assign rif.rvalid  = rvalid;
  assign rif.rempty  = rempty;
  assign rif.raempty = raempty;
  assign rif.rlevel  = rlevel;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed bench for fifo_rd_ctrl; the bench plays the write
// domain and the dual-port memory.
module tb_fifo_rd_ctrl;
  logic rclk = 0;
  logic rrst_n = 0;
  logic [7:0] mem [16];
  int tests = 0;
  int fails = 0;
  fifo_rd_ctrl_if #(.ASIZE(4), .DSIZE(8)) rif ();
  fifo_rd_ctrl #(.ASIZE(4), .DSIZE(8), .AEMPTY(2)) dut (.rclk(rclk), .rrst_n(rrst_n), .rif(rif.slave));
  assign rif.mem_rdata = mem[rif.raddr];
  always #5 rclk = ~rclk;

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    for (int i = 0; i < 5; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rrst_n = 0;
    rif.rq2_wptr = '0;
    rif.rready = 0;
    repeat (2) tick();
    rrst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (rif.rempty !== 1'b1) begin fails++; $display("FAIL reset_rempty got %0b exp 1", rif.rempty); end
    tests++; if (rif.rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %0b exp 0", rif.rvalid); end
    tests++; if (rif.rlevel !== 5'd0) begin fails++; $display("FAIL reset_rlevel got %0d exp 0", rif.rlevel); end
    tests++; if (rif.raempty !== 1'b1) begin fails++; $display("FAIL reset_raempty got %0b exp 1", rif.raempty); end
    tests++; if (rif.rptr !== 5'd0) begin fails++; $display("FAIL reset_rptr got %0h exp 0", rif.rptr); end
    for (int i = 0; i < 4; i++) begin
      rif.rready = i[0];
      tick();
      tests++;
      if (rif.rvalid !== 1'b0 || rif.rempty !== 1'b1 || rif.rlevel !== 5'd0 || rif.rptr !== 5'd0)
        begin fails++; $display("FAIL idle_rready cyc %0d got v=%0b e=%0b l=%0d p=%0h exp v=0 e=1 l=0 p=0", i, rif.rvalid, rif.rempty, rif.rlevel, rif.rptr); end
    end
  endtask

  task automatic test_step();
    do_reset();
    mem[0] = 8'hA5;
    rif.rq2_wptr = gray(1);
    tick();
    tests++; if (rif.rempty !== 1'b0) begin fails++; $display("FAIL step_e1_rempty got %0b exp 0", rif.rempty); end
    tests++; if (rif.rlevel !== 5'd1) begin fails++; $display("FAIL step_e1_rlevel got %0d exp 1", rif.rlevel); end
    tests++; if (rif.rvalid !== 1'b0) begin fails++; $display("FAIL step_e1_rvalid got %0b exp 0", rif.rvalid); end
    tick();
    tests++; if (rif.rvalid !== 1'b1) begin fails++; $display("FAIL step_e2_rvalid got %0b exp 1", rif.rvalid); end
    tests++; if (rif.rdata !== 8'hA5) begin fails++; $display("FAIL step_e2_rdata got %0h exp a5", rif.rdata); end
    tests++; if (rif.rempty !== 1'b1) begin fails++; $display("FAIL step_e2_rempty got %0b exp 1", rif.rempty); end
    tests++; if (rif.rptr !== 5'b00001) begin fails++; $display("FAIL step_e2_rptr got %0b exp 00001", rif.rptr); end
    tests++; if (rif.rlevel !== 5'd1) begin fails++; $display("FAIL step_e2_rlevel got %0d exp 1", rif.rlevel); end
    tests++; if (rif.raempty !== 1'b1) begin fails++; $display("FAIL step_e2_raempty got %0b exp 1", rif.raempty); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] lvl [7] = '{5, 5, 4, 3, 2, 1, 0};
    logic rv [7] = '{0, 1, 1, 1, 1, 1, 0};
    logic ae [7] = '{0, 0, 0, 0, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 5; i++) mem[i] = 8'(8'h10 + i);
    rif.rq2_wptr = gray(5);
    rif.rready = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      tests++;
      if (rif.rlevel !== lvl[i] || rif.rvalid !== rv[i] || rif.raempty !== ae[i])
        begin fails++; $display("FAIL b2b_status cyc %0d got l=%0d v=%0b ae=%0b exp l=%0d v=%0b ae=%0b", i, rif.rlevel, rif.rvalid, rif.raempty, lvl[i], rv[i], ae[i]); end
      if (rv[i]) begin
        tests++;
        if (rif.rdata !== 8'(8'h10 + i - 1)) begin fails++; $display("FAIL b2b_rdata cyc %0d got %0h exp %0h", i, rif.rdata, 8'(8'h10 + i - 1)); end
      end
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h40 + i);
    rif.rq2_wptr = gray(16);
    repeat (2) tick();
    tests++; if (rif.rlevel !== 5'd16) begin fails++; $display("FAIL fill_first_level got %0d exp 16", rif.rlevel); end
    mem[0] = 8'h50;
    rif.rq2_wptr = gray(17);
    tick();
    tests++; if (rif.rlevel !== 5'd17) begin fails++; $display("FAIL fill_rlevel got %0d exp 17", rif.rlevel); end
    tests++; if (rif.raddr !== 4'd1) begin fails++; $display("FAIL fill_raddr got %0d exp 1", rif.raddr); end
    tests++; if (rif.rempty !== 1'b0) begin fails++; $display("FAIL fill_rempty got %0b exp 0", rif.rempty); end
    tests++; if (rif.rvalid !== 1'b1 || rif.rdata !== 8'h40) begin fails++; $display("FAIL fill_head got v=%0b d=%0h exp v=1 d=40", rif.rvalid, rif.rdata); end
    tests++; if (rif.raempty !== 1'b0) begin fails++; $display("FAIL fill_raempty got %0b exp 0", rif.raempty); end
    rif.rready = 1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      tests++;
      if (rif.rvalid !== 1'b1 || rif.rdata !== ((k == 16) ? 8'h50 : 8'(8'h40 + k)))
        begin fails++; $display("FAIL fill_drain k=%0d got v=%0b d=%0h exp v=1 d=%0h", k, rif.rvalid, rif.rdata, (k == 16) ? 8'h50 : 8'(8'h40 + k)); end
    end
    tick();
    tests++; if (rif.rvalid !== 1'b0 || rif.rlevel !== 5'd0) begin fails++; $display("FAIL fill_empty got v=%0b l=%0d exp v=0 l=0", rif.rvalid, rif.rlevel); end
  endtask

  task automatic test_wrap();
    int wcnt = 0, rcnt = 0, cyc = 0;
    logic [4:0] prev = '0;
    logic [4:0] occ;
    logic [15:0] seen = '0;
    bit wrapped = 0;
    do_reset();
    while (rcnt < 40 && cyc < 600) begin
      occ = 5'(wcnt) - g2b(rif.rptr);
      if (wcnt < 40 && occ < 5'd16) begin
        mem[wcnt % 16] = 8'(wcnt * 7 + 3);
        wcnt++;
        rif.rq2_wptr = gray(wcnt);
      end
      rif.rready = 1'($urandom_range(0, 1));
      if (rif.rvalid && rif.rready) begin
        tests++;
        if (rif.rdata !== 8'(rcnt * 7 + 3)) begin fails++; $display("FAIL wrap_order word %0d got %0h exp %0h", rcnt, rif.rdata, 8'(rcnt * 7 + 3)); end
        rcnt++;
      end
      seen[rif.raddr] = 1'b1;
      if (prev == 5'b10000 && rif.rptr == 5'b00000) wrapped = 1;
      prev = rif.rptr;
      tick();
      cyc++;
    end
    rif.rready = 0;
    repeat (2) tick();
    tests++; if (rcnt != 40) begin fails++; $display("FAIL wrap_count got %0d exp 40 (cycle budget)", rcnt); end
    tests++; if (!wrapped) begin fails++; $display("FAIL wrap_rptr got no 10000->00000 exp roll seen"); end
    tests++; if (seen !== 16'hFFFF) begin fails++; $display("FAIL wrap_raddr got %0h exp ffff", seen); end
    tests++; if (rif.rvalid !== 1'b0 || rif.rempty !== 1'b1 || rif.rlevel !== 5'd0)
      begin fails++; $display("FAIL wrap_end got v=%0b e=%0b l=%0d exp v=0 e=1 l=0", rif.rvalid, rif.rempty, rif.rlevel); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h80 + i);
    rif.rq2_wptr = gray(8);
    repeat (2) tick();
    rif.rready = 1;
    repeat (2) tick();
    rif.rready = 0;
    tick();
    tests++; if (rif.rvalid !== 1'b1 || rif.rlevel !== 5'd6) begin fails++; $display("FAIL arst_pre got v=%0b l=%0d exp v=1 l=6", rif.rvalid, rif.rlevel); end
    #2 rrst_n = 0;
    #1;
    tests++;
    if (rif.rvalid !== 1'b0 || rif.rempty !== 1'b1 || rif.rlevel !== 5'd0 || rif.raempty !== 1'b1 ||
        rif.rptr !== 5'd0 || rif.rdata !== 8'h00 || rif.raddr !== 4'd0)
      begin fails++; $display("FAIL arst_now got v=%0b e=%0b l=%0d ae=%0b p=%0h d=%0h a=%0d exp 0 1 0 1 0 0 0", rif.rvalid, rif.rempty, rif.rlevel, rif.raempty, rif.rptr, rif.rdata, rif.raddr); end
    rif.rq2_wptr = '0;
    repeat (2) tick();
    rrst_n = 1;
    repeat (2) tick();
    tests++; if (rif.rvalid !== 1'b0 || rif.rempty !== 1'b1 || rif.rlevel !== 5'd0 || rif.rptr !== 5'd0)
      begin fails++; $display("FAIL arst_idle got v=%0b e=%0b l=%0d p=%0h exp 0 1 0 0", rif.rvalid, rif.rempty, rif.rlevel, rif.rptr); end
    mem[0] = 8'h3C;
    rif.rq2_wptr = gray(1);
    repeat (2) tick();
    tests++; if (rif.rvalid !== 1'b1 || rif.rdata !== 8'h3C || rif.rptr !== 5'b00001)
      begin fails++; $display("FAIL arst_restart got v=%0b d=%0h p=%0b exp v=1 d=3c p=00001", rif.rvalid, rif.rdata, rif.rptr); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rif.rq2_wptr = '0;
    rif.rready = 0;
    test_reset();
    test_step();
    test_back_to_back();
    test_fill();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
